// File: rtl/otter_route_pkg.sv
// rtl/otter_route_pkg.sv - shared types for the OTTER response router
package otter_route_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  typedef enum logic {
    ROUTE_IF = 1'b0,
    ROUTE_LD = 1'b1
  } route_sel_t;

  localparam int MAX_DEPTH = 2;

endpackage

// File: rtl/route_fifo.sv
// rtl/route_fifo.sv - one- or two-entry elastic buffer with occupancy state machine
// The head word is kept in its own register so it holds its value once the buffer drains.
module route_fifo
  import otter_route_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             head_valid_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic             full_o,
  output logic [1:0]       count_o
);

  occ_state_t       state_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mem_q [MAX_DEPTH];
  logic             push_ok;
  logic             pop_ok;

  function automatic logic next_ptr(input logic p);
    return (p == 1'(DEPTH - 1)) ? 1'b0 : ~p;
  endfunction

  // With a single entry, holding one word already means no room.
  assign full_o       = (state_q == OCC_FULL) || ((DEPTH == 1) && (state_q == OCC_ONE));
  assign head_valid_o = (state_q != OCC_EMPTY);
  assign head_data_o  = data_q;
  assign count_o      = state_q;
  assign push_ok      = push_i && !full_o;
  assign pop_ok       = head_valid_o && pop_ready_i;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= OCC_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      data_q   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case (state_q)
        OCC_EMPTY: begin
          if (push_ok) begin
            state_q <= OCC_ONE;
            data_q  <= push_data_i;
          end
        end
        OCC_ONE: begin
          if (push_ok && pop_ok) begin
            data_q <= push_data_i;
          end else if (push_ok) begin
            state_q <= OCC_FULL;
          end else if (pop_ok) begin
            state_q <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // The second word was written on an earlier edge, so it is already in storage.
          if (pop_ok) begin
            state_q <= OCC_ONE;
            data_q  <= mem_q[next_ptr(rd_ptr_q)];
          end
        end
        default: state_q <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/demux_route_1to2.sv
// rtl/demux_route_1to2.sv - registered 1-to-2 demux steering a stream into two buffered ports
// Port 0 carries instruction fetch responses, port 1 carries data load responses.
module demux_route_1to2
  import otter_route_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [1:0]       out0_count,
  output logic [1:0]       out1_count
);

  route_sel_t sel;
  logic       full0;
  logic       full1;
  logic       push0;
  logic       push1;

  assign sel = route_sel_t'(in_sel);

  // Ready depends only on registered fullness and in_sel; a consumer pop never frees space early.
  assign in_ready = !RST && ((sel == ROUTE_LD) ? !full1 : !full0);
  assign push0    = in_valid && in_ready && (sel == ROUTE_IF);
  assign push1    = in_valid && in_ready && (sel == ROUTE_LD);

  route_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_if (
    .clk_i        (CLK),
    .rst_i        (RST),
    .push_i       (push0),
    .push_data_i  (in_data),
    .pop_ready_i  (out0_ready),
    .head_valid_o (out0_valid),
    .head_data_o  (out0_data),
    .full_o       (full0),
    .count_o      (out0_count)
  );

  route_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_ld (
    .clk_i        (CLK),
    .rst_i        (RST),
    .push_i       (push1),
    .push_data_i  (in_data),
    .pop_ready_i  (out1_ready),
    .head_valid_o (out1_valid),
    .head_data_o  (out1_data),
    .full_o       (full1),
    .count_o      (out1_count)
  );

endmodule
